// File: rtl/pronoc_pkg.sv
// Shared fmesh routing definitions: router port indices, the coded
// destination-port record and the edge-port placement rule.
package pronoc_pkg;

  localparam int LOCAL = 0;
  localparam int EAST  = 1;
  localparam int NORTH = 2;
  localparam int WEST  = 3;
  localparam int SOUTH = 4;

  // Packed MSB-first so that a plain cast yields the {x,y,a,b} nibble.
  typedef struct packed {
    logic x;
    logic y;
    logic a;
    logic b;
  } fmesh_rt_s;

  // An endpoint on an edge port only exists on a router that sits on that edge.
  function automatic logic edge_port_ok(input int ep, input logic at_e, input logic at_n,
                                        input logic at_w, input logic at_s);
    case (ep)
      LOCAL:   return 1'b1;
      EAST:    return at_e;
      NORTH:   return at_n;
      WEST:    return at_w;
      SOUTH:   return at_s;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fmesh_route_compare.sv
// Combinational route logic: the decode half feeds stage 1, the coding half
// turns the stage-1 fields into the {x,y,a,b} code and the local-port number.
module fmesh_route_compare
  import pronoc_pkg::*;
#(
  parameter int    NX         = 2,
  parameter int    NY         = 2,
  parameter int    NL         = 1,
  parameter int    EAw        = 5,
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    PLw        = 3,
  localparam int   EXw        = $clog2(NX),
  localparam int   EYw        = $clog2(NY)
) (
  input  logic [EAw-1:0] i_e_addr,
  input  logic [EXw-1:0] i_cur_x,
  input  logic [EYw-1:0] i_cur_y,
  output logic           o_dec_ok,
  output logic [PLw-1:0] o_dec_localp,
  output logic           o_dec_gt_x,
  output logic           o_dec_lt_y,
  output logic           o_dec_dx,
  output logic           o_dec_dy,
  input  logic           i_s1_ok,
  input  logic [PLw-1:0] i_s1_localp,
  input  logic           i_s1_gt_x,
  input  logic           i_s1_lt_y,
  input  logic           i_s1_dx,
  input  logic           i_s1_dy,
  output fmesh_rt_s      o_rt,
  output logic [PLw-1:0] o_localp
);

  localparam int  EPw    = EAw - EXw - EYw;
  localparam int  P      = 4 + NL;
  localparam bit  IS_DET = (ROUTE_TYPE == "DETERMINISTIC");
  localparam logic [EXw-1:0] X_MAX = EXw'(NX - 1);
  localparam logic [EYw-1:0] Y_MAX = EYw'(NY - 1);
  localparam logic [EPw-1:0] P_MAX = EPw'(P - 1);

  logic [EXw-1:0] w_ex;
  logic [EYw-1:0] w_ey;
  logic [EPw-1:0] w_ep;
  logic           w_in_range;
  logic           w_edge_ok;
  logic           w_move_x;
  logic           w_move_y;

  assign w_ex = i_e_addr[EXw-1:0];
  assign w_ey = i_e_addr[EXw +: EYw];
  assign w_ep = i_e_addr[EAw-1 -: EPw];

  assign w_in_range = (w_ex <= X_MAX) && (w_ey <= Y_MAX) && (w_ep <= P_MAX);
  assign w_edge_ok  = edge_port_ok(int'(w_ep), w_ex == X_MAX, w_ey == '0,
                                   w_ex == '0, w_ey == Y_MAX);

  assign o_dec_ok     = w_in_range & w_edge_ok;
  assign o_dec_localp = PLw'(w_ep);
  assign o_dec_gt_x   = w_ex > i_cur_x;
  assign o_dec_lt_y   = w_ey < i_cur_y;
  assign o_dec_dx     = w_ex != i_cur_x;
  assign o_dec_dy     = w_ey != i_cur_y;

  // XY finishes the x leg before any y move; adaptive offers both productive moves.
  assign w_move_x = i_s1_ok & i_s1_dx;
  assign w_move_y = i_s1_ok & i_s1_dy & (IS_DET ? ~i_s1_dx : 1'b1);

  assign o_rt.a   = w_move_x;
  assign o_rt.b   = w_move_y;
  assign o_rt.x   = w_move_x & i_s1_gt_x;
  assign o_rt.y   = w_move_y & i_s1_lt_y;
  assign o_localp = i_s1_ok ? i_s1_localp : '0;

endmodule

// File: rtl/fmesh_route_encoder.sv
// Two-stage route-computation pipeline with valid/ready flow control and a
// saturating count of invalid headers handed to the consumer.
module fmesh_route_encoder
  import pronoc_pkg::*;
#(
  parameter int    NX         = 2,
  parameter int    NY         = 2,
  parameter int    NL         = 1,
  parameter int    EAw        = 5,
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    DSTPw      = 4,
  parameter int    PLw        = 3,
  parameter int    TAGw       = 4,
  parameter int    ERRw       = 8,
  localparam int   EXw        = $clog2(NX),
  localparam int   EYw        = $clog2(NY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EXw-1:0]   current_x,
  input  logic [EYw-1:0]   current_y,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EAw-1:0]   in_e_addr,
  input  logic [TAGw-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSTPw-1:0] dest_port_coded,
  output logic [PLw-1:0]   endp_localp_num,
  output logic [TAGw-1:0]  out_tag,
  output logic             out_err,
  output logic [ERRw-1:0]  err_cnt
);

  logic            w_dec_ok, w_dec_gt_x, w_dec_lt_y, w_dec_dx, w_dec_dy;
  logic [PLw-1:0]  w_dec_localp;
  fmesh_rt_s       w_rt;
  logic [PLw-1:0]  w_localp;
  logic            w_s2_adv;
  logic            w_in_ready;

  logic            r_s1_valid;
  logic            r_s1_ok, r_s1_gt_x, r_s1_lt_y, r_s1_dx, r_s1_dy;
  logic [PLw-1:0]  r_s1_localp;
  logic [TAGw-1:0] r_s1_tag;

  logic             r_out_valid;
  logic [DSTPw-1:0] r_dest;
  logic [PLw-1:0]   r_localp;
  logic [TAGw-1:0]  r_tag;
  logic             r_err;
  logic [ERRw-1:0]  r_err_cnt;

  fmesh_route_compare #(
    .NX(NX), .NY(NY), .NL(NL), .EAw(EAw), .ROUTE_TYPE(ROUTE_TYPE), .PLw(PLw)
  ) u_compare (
    .i_e_addr    (in_e_addr),
    .i_cur_x     (current_x),
    .i_cur_y     (current_y),
    .o_dec_ok    (w_dec_ok),
    .o_dec_localp(w_dec_localp),
    .o_dec_gt_x  (w_dec_gt_x),
    .o_dec_lt_y  (w_dec_lt_y),
    .o_dec_dx    (w_dec_dx),
    .o_dec_dy    (w_dec_dy),
    .i_s1_ok     (r_s1_ok),
    .i_s1_localp (r_s1_localp),
    .i_s1_gt_x   (r_s1_gt_x),
    .i_s1_lt_y   (r_s1_lt_y),
    .i_s1_dx     (r_s1_dx),
    .i_s1_dy     (r_s1_dy),
    .o_rt        (w_rt),
    .o_localp    (w_localp)
  );

  assign w_s2_adv   = ~r_out_valid | out_ready;
  assign w_in_ready = ~r_s1_valid | w_s2_adv;

  // NOTE: non-blocking assignments let every stage read last cycle's value of
  // the stage ahead, which is what makes simultaneous accept and drain safe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  // NOTE: stage-1 payload has no reset; r_s1_valid alone qualifies it, so
  // stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (w_in_ready && in_valid) begin
      r_s1_ok     <= w_dec_ok;
      r_s1_localp <= w_dec_localp;
      r_s1_gt_x   <= w_dec_gt_x;
      r_s1_lt_y   <= w_dec_lt_y;
      r_s1_dx     <= w_dec_dx;
      r_s1_dy     <= w_dec_dy;
      r_s1_tag    <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_dest      <= '0;
      r_localp    <= '0;
      r_tag       <= '0;
      r_err       <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dest   <= DSTPw'(w_rt);
        r_localp <= w_localp;
        r_tag    <= r_s1_tag;
        r_err    <= ~r_s1_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (r_out_valid && out_ready && r_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + ERRw'(1);
    end
  end

  assign in_ready        = w_in_ready;
  assign out_valid       = r_out_valid;
  assign dest_port_coded = r_dest;
  assign endp_localp_num = r_localp;
  assign out_tag         = r_tag;
  assign out_err         = r_err;
  assign err_cnt         = r_err_cnt;

endmodule
